// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file / scoreboard slice.
package regfile_pkg;
  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;
  localparam int NRD_D   = 2;
  localparam int NWR_D   = 1;
  localparam int AW_D    = $clog2(NREGS_D);
  localparam int A0_IDX  = 10;

  typedef logic [AW_D-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Pending-write scoreboard: one busy bit per architectural register.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_D,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [AW-1:0]    issue_rd,
  input  logic [NREGS-1:0] commit,
  input  logic             flush,
  output logic [NREGS-1:0] busy
);
  logic [NREGS-1:0] nxt;

  // Issue is applied after clear/flush so a new producer always wins.
  always_comb begin
    nxt = flush ? '0 : (busy & ~commit);
    if (issue && issue_rd != '0) nxt[issue_rd] = 1'b1;
    nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= nxt;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with x0 hardwired, write bypass and hazard flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD   = NRD_D,
  parameter int NWR   = NWR_D,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NWR-1:0]            WE,
  input  logic [NWR-1:0][AW-1:0]    AD_W,
  input  logic [NWR-1:0][XLEN-1:0]  WD,
  input  logic [NRD-1:0][AW-1:0]    AD_R,
  output logic [NRD-1:0][XLEN-1:0]  RD,
  output logic [NRD-1:0]            RD_busy,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_rd,
  input  logic                      flush,
  output logic [NREGS-1:0]          busy_vec,
  output logic [XLEN-1:0]           a0
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0][XLEN-1:0] wdat;
  logic [NREGS-1:0]           wcommit;
  logic [NREGS-1:0]           busy;

  // Later ports overwrite earlier ones, so port NWR-1 wins collisions.
  // Commits are suppressed in reset so bypass reads return 0 too.
  always_comb begin
    wcommit = '0;
    wdat    = '0;
    for (int i = 0; i < NWR; i++) begin
      if (WE[i] && AD_W[i] != '0 && !rst) begin
        wcommit[AD_W[i]] = 1'b1;
        wdat[AD_W[i]]    = WD[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++)
        if (wcommit[r]) regs[r] <= wdat[r];
    end
  end

  reg_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .issue    (iss_valid),
    .issue_rd (iss_rd),
    .commit   (wcommit),
    .flush    (flush),
    .busy     (busy)
  );

  assign busy_vec = busy;

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] a;
    assign a          = AD_R[j];
    assign RD[j]      = (a == '0) ? '0 : (wcommit[a] ? wdat[a] : regs[a]);
    assign RD_busy[j] = busy[a] & ~wcommit[a];
  end

  if (NREGS > A0_IDX) begin : g_a0
    assign a0 = regs[A0_IDX];
  end else begin : g_no_a0
    assign a0 = '0;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (NRD=2, NWR=2).
module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NWR-1:0]           WE;
  logic [NWR-1:0][AW-1:0]   AD_W;
  logic [NWR-1:0][XLEN-1:0] WD;
  logic [NRD-1:0][AW-1:0]   AD_R;
  logic [NRD-1:0][XLEN-1:0] RD;
  logic [NRD-1:0]           RD_busy;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     flush;
  logic [NREGS-1:0]         busy_vec;
  logic [XLEN-1:0]          a0;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .WE(WE), .AD_W(AD_W), .WD(WD), .AD_R(AD_R),
    .RD(RD), .RD_busy(RD_busy), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .busy_vec(busy_vec), .a0(a0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE = '0; AD_W = '0; WD = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; AD_R = '0;
    idle();
    tick(); tick();
    chk("reset_rd0",     RD[0],    32'h0);
    chk("reset_busyvec", busy_vec, 32'h0);
    chk("reset_a0",      a0,       32'h0);
    rst = 1'b0;

    // bypass on write to r5
    WE[0] = 1'b1; AD_W[0] = 5'd5; WD[0] = 32'h1234; AD_R[0] = 5'd5;
    #1 chk("bypass_same", RD[0], 32'h1234);
    tick(); idle();
    #1 chk("bypass_next", RD[0], 32'h1234);

    // x0 stays zero
    WE[0] = 1'b1; AD_W[0] = 5'd0; WD[0] = 32'hDEADBEEF;
    tick(); idle(); AD_R[0] = 5'd0;
    #1 chk("x0_rd",      RD[0],             32'h0);
    chk("x0_rdbusy",     {31'b0, RD_busy[0]}, 32'h0);
    chk("x0_busyvec",    busy_vec,          32'h0);

    // hazard on r7
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick(); idle(); AD_R[1] = 5'd7;
    #1 chk("haz_rdbusy_set", {31'b0, RD_busy[1]}, 32'h1);
    chk("haz_busyvec_set", {31'b0, busy_vec[7]}, 32'h1);
    WE[0] = 1'b1; AD_W[0] = 5'd7; WD[0] = 32'hAA;
    #1 chk("haz_rdbusy_clr", {31'b0, RD_busy[1]}, 32'h0);
    chk("haz_rd_bypass",   RD[1], 32'hAA);
    tick(); idle();
    #1 chk("haz_busyvec_clr", {31'b0, busy_vec[7]}, 32'h0);
    chk("haz_rd_stored",   RD[1], 32'hAA);

    // issue and write r9 together: producer wins
    iss_valid = 1'b1; iss_rd = 5'd9; WE[0] = 1'b1; AD_W[0] = 5'd9; WD[0] = 32'h77;
    tick(); idle(); AD_R[0] = 5'd9;
    #1 chk("coll_busy9",    {31'b0, busy_vec[9]}, 32'h1);
    chk("coll_rd9",         RD[0], 32'h77);
    chk("coll_rdbusy9",     {31'b0, RD_busy[0]}, 32'h1);

    // both write ports to r3: port 1 wins
    WE = 2'b11; AD_W[0] = 5'd3; WD[0] = 32'h1; AD_W[1] = 5'd3; WD[1] = 32'h2; AD_R[0] = 5'd3;
    #1 chk("dual_bypass", RD[0], 32'h2);
    tick(); idle();
    #1 chk("dual_stored", RD[0], 32'h2);

    // flush with concurrent issue
    iss_valid = 1'b1; iss_rd = 5'd4; tick();
    iss_rd = 5'd6; tick(); idle();
    #1 chk("flush_pre", busy_vec, 32'h0000_0250);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd8;
    tick(); idle();
    #1 chk("flush_post", busy_vec, 32'h0000_0100);
    WE[0] = 1'b1; AD_W[0] = 5'd10; WD[0] = 32'h55;
    #1 chk("a0_no_bypass", a0, 32'h0);
    tick(); idle();
    #1 chk("a0_written", a0, 32'h55);

    // async reset mid-cycle with registers loaded
    AD_R[0] = 5'd3; AD_R[1] = 5'd8;
    #1 rst = 1'b1;
    #1 chk("rst_rd_async",  RD[0],    32'h0);
    chk("rst_a0_async",     a0,       32'h0);
    chk("rst_busy_async",   busy_vec, 32'h0);
    chk("rst_rdbusy_async", {31'b0, RD_busy[1]}, 32'h0);
    WE[0] = 1'b1; AD_W[0] = 5'd5; WD[0] = 32'hFF; AD_R[0] = 5'd5;
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1 chk("rst_no_bypass", RD[0], 32'h0);
    tick();
    #1 chk("rst_write_ignored", RD[0],    32'h0);
    chk("rst_issue_ignored",    busy_vec, 32'h0);
    rst = 1'b0; idle();
    WE[0] = 1'b1; AD_W[0] = 5'd5; WD[0] = 32'h99;
    tick(); idle();
    #1 chk("post_rst_write", RD[0], 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, at least 2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, read-port count (1..4).
REQ-004 SHALL have parameter NWR, default 1, write-port count (1..2).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port WE  in  NWR  per-port write enable.
REQ-008 SHALL have port AD_W  in  NWR x AW  per-port write address.
REQ-009 SHALL have port WD  in  NWR x XLEN  per-port write data.
REQ-010 SHALL have port AD_R  in  NRD x AW  per-port read address.
REQ-011 SHALL have port RD  out  NRD x XLEN  per-port read data.
REQ-012 SHALL have port RD_busy  out  NRD  per-port hazard flag, 1 = operand not yet available.
REQ-013 SHALL have port iss_valid  in  1  instruction issue strobe; marks iss_rd pending.
REQ-014 SHALL have port iss_rd  in  AW  destination register of the issued instruction.
REQ-015 SHALL have port flush  in  1  clears all pending marks.
REQ-016 SHALL have port busy_vec  out  NREGS  current pending bit per register.
REQ-017 SHALL have port a0  out  XLEN  registered value of register 10 (debug/test result).

Function
REQ-018 Writes SHALL commit on rising clk when WE[i]=1 and AD_W[i]!=0; register 0 SHALL never be written.
REQ-019 If both write ports target the same non-zero address in one cycle, port NWR-1 SHALL win.
REQ-020 Reads SHALL be combinational; address 0 SHALL return 0 and RD_busy=0.
REQ-021 Read bypass: if a write commits to AD_R[j] this cycle, RD[j] SHALL return that WD (winner per REQ-019), not the stale value.
REQ-022 busy[r] SHALL be set on the clk edge after iss_valid=1 with iss_rd=r, r!=0.
REQ-023 busy[r] SHALL be cleared on the clk edge when a write commits to r.
REQ-024 Simultaneous issue and write to the same r SHALL leave busy[r]=1 (new producer wins).
REQ-025 flush=1 SHALL clear all busy bits on the next edge; an iss_valid in the same cycle SHALL still set its bit.
REQ-026 RD_busy[j] SHALL be busy[AD_R[j]] AND NOT (write committing to AD_R[j] this cycle).
REQ-027 busy_vec SHALL reflect the registered busy bits; bit 0 SHALL be constant 0.
REQ-028 a0 SHALL reflect register 10 contents with no bypass (value after last committed write).
REQ-029 Write data/enable with X-free inputs SHALL never corrupt any register other than the addressed one.

Reset
REQ-030 rst=1 SHALL asynchronously clear all registers, all busy bits, and therefore a0, busy_vec, and RD_busy to 0.
REQ-031 While rst=1, writes and issues SHALL be ignored; RD SHALL read 0 except same-cycle bypass SHALL be suppressed.
REQ-032 Deassertion SHALL be taken on a clk edge; the first edge after deassertion SHALL accept writes and issues.

Structure
REQ-033 Package regfile_pkg SHALL hold default XLEN, NREGS, NRD, NWR, derived AW, and the register-index typedef.
REQ-034 The pending-bit logic SHALL be a sub-module reg_scoreboard (inputs: issue, write-commit vector, flush; output: busy vector).
REQ-035 The write-port resolve (enable gating, x0 mask, priority) SHALL produce one per-register commit vector shared by storage and scoreboard.

Verification
REQ-036 Reset: assert rst mid-run with regs loaded -> RD, a0, busy_vec all 0 immediately, before any clk edge.
REQ-037 x0: WE=1, AD_W=0, WD=32'hDEADBEEF; then AD_R=0 -> RD=0, RD_busy=0.
REQ-038 Bypass: WE=1, AD_W=5, WD=32'h1234 with AD_R[0]=5 same cycle -> RD[0]=32'h1234; next cycle with WE=0 still 32'h1234.
REQ-039 Hazard: iss_valid, iss_rd=7; next cycle AD_R[1]=7 -> RD_busy[1]=1; write to 7 with 32'hAA -> same cycle RD_busy[1]=0, RD[1]=32'hAA; next cycle busy_vec[7]=0.
REQ-040 Collision: issue rd=9 and write 9 same cycle -> busy_vec[9]=1 afterward; NWR=2 both ports write 3 (32'h1, 32'h2) -> reg 3=32'h2.
REQ-041 Flush: busy regs 4,6 set; flush with iss_valid rd=8 -> busy_vec has only bit 8 set; write 10 with 32'h55 -> a0=32'h55 next cycle.
